// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ring sequencer.
package alarm_pkg;

  localparam int TIME_W      = 16;
  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [2:0] {
    DISARMED,
    WAIT_MATCH,
    RINGING,
    SNOOZE,
    DONE
  } alarm_state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/second_timer.sv
// Loadable down-counter of one_second strobes; expired marks the strobe that
// arrives while the count is 1, so a load of N expires on the Nth strobe.
module second_timer #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             one_second,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  assign expired = one_second && (r_count == WIDTH'(1));

  // A load always wins over a strobe in the same cycle; the count parks at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (one_second && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sounder sequencer: rings on time match, handles stop/snooze buttons,
// a bounded number of snoozes and a ring timeout.
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              one_second,
  input  logic                              alarm_enable,
  input  logic [TIME_W-1:0]                 alarm_time,
  input  logic [TIME_W-1:0]                 current_time,
  input  logic                              stop_button,
  input  logic                              snooze_button,
  output logic                              sound_alarm,
  output logic                              ringing,
  output logic                              snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_count
);

  localparam int CNT_W   = $clog2(MAX_SNOOZE + 1);
  localparam int TIMER_W = $clog2(maxOf(RING_SEC, SNOOZE_SEC) + 1);

  alarm_state_e     r_state;
  alarm_state_e     w_nextState;
  logic [CNT_W-1:0] w_nextCount;
  logic             r_stopPrev;
  logic             r_snoozePrev;
  logic             r_stopEdge;
  logic             r_snoozeEdge;
  logic             w_match;
  logic             w_tick;
  logic             w_load;
  logic [TIMER_W-1:0] w_loadValue;
  logic             w_expired;

  assign w_match = (current_time == alarm_time);
  assign w_tick  = one_second && ((r_state == RINGING) || (r_state == SNOOZE));

  // Edges are registered, so a press reaches the FSM one cycle after it is seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stopPrev   <= 1'b0;
      r_snoozePrev <= 1'b0;
      r_stopEdge   <= 1'b0;
      r_snoozeEdge <= 1'b0;
    end else begin
      r_stopPrev   <= stop_button;
      r_snoozePrev <= snooze_button;
      r_stopEdge   <= stop_button && !r_stopPrev;
      r_snoozeEdge <= snooze_button && !r_snoozePrev;
    end
  end

  second_timer #(
    .WIDTH(TIMER_W)
  ) u_second_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_loadValue),
    .one_second (w_tick),
    .expired    (w_expired)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextCount = snooze_count;
    w_load      = 1'b0;
    w_loadValue = '0;
    if (!alarm_enable) begin
      w_nextState = DISARMED;
      w_nextCount = '0;
    end else begin
      case (r_state)
        DISARMED: w_nextState = w_match ? DONE : WAIT_MATCH;
        WAIT_MATCH: begin
          if (w_match) begin
            w_nextState = RINGING;
            w_nextCount = '0;
            w_load      = 1'b1;
            w_loadValue = TIMER_W'(RING_SEC);
          end
        end
        RINGING: begin
          // Stop beats snooze, and any button edge beats a coincident timeout.
          if (r_stopEdge) begin
            w_nextState = DONE;
          end else if (r_snoozeEdge || w_expired) begin
            if (snooze_count < CNT_W'(MAX_SNOOZE)) begin
              w_nextState = SNOOZE;
              w_nextCount = snooze_count + CNT_W'(1);
              w_load      = 1'b1;
              w_loadValue = TIMER_W'(SNOOZE_SEC);
            end else begin
              w_nextState = DONE;
            end
          end
        end
        SNOOZE: begin
          if (r_stopEdge) begin
            w_nextState = DONE;
          end else if (w_expired) begin
            w_nextState = RINGING;
            w_load      = 1'b1;
            w_loadValue = TIMER_W'(RING_SEC);
          end
        end
        DONE: begin
          if (!w_match) begin
            w_nextState = WAIT_MATCH;
          end
        end
        default: w_nextState = DISARMED;
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= DISARMED;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      sound_alarm  <= 1'b0;
      snooze_count <= '0;
    end else begin
      r_state      <= w_nextState;
      ringing      <= (w_nextState == RINGING);
      snoozing     <= (w_nextState == SNOOZE);
      snooze_count <= w_nextCount;
      if (w_nextState != RINGING) begin
        sound_alarm <= 1'b0;
      end else if (r_state != RINGING) begin
        sound_alarm <= 1'b1;
      end else if (one_second) begin
        sound_alarm <= !sound_alarm;
      end
    end
  end

endmodule
